// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 character LCD write-only driver with power-up init sequence
module lcd_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 13,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 1080,
    parameter int T_CLR   = 44280,
    parameter int T_PWR   = 405000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       init_done_o,
    output logic       lcd_en_o,
    output logic       lcd_rw_o,
    output logic       lcd_rs_o,
    output logic       lcd_on_o,
    output logic [7:0] lcd_data_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A zero delay would never expire, so every phase lasts at least one cycle
    localparam int TS = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int TE = (T_EN    < 1) ? 1 : T_EN;
    localparam int TH = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int TC = (T_CMD   < 1) ? 1 : T_CMD;
    localparam int TL = (T_CLR   < 1) ? 1 : T_CLR;
    localparam int TP = (T_PWR   < 1) ? 1 : T_PWR;

    // SETUP is loaded with TS+1: RS/DATA change on the load edge itself, so the
    // first cycle of SETUP is the bus settling before the TS-cycle setup window
    localparam int T_MAX = max2(max2(max2(TS + 1, TE), max2(TH, TC)), max2(TL, TP));
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      init_idx, init_idx_n;
    logic            done_q, done_n;
    logic            ready_q, ready_n;
    logic            en_q, en_n;
    logic            rs_q, rs_n;
    logic [7:0]      data_q, data_n;
    logic            on_q;
    logic            load;
    logic            load_rs;
    logic [7:0]      load_data;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear and return-home commands need the long execution wait
    function automatic logic is_long(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    // Next-state logic: phase sequencing, byte loading and registered output values
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        init_idx_n = init_idx;
        done_n     = done_q;
        rs_n       = rs_q;
        data_n     = data_q;
        en_n       = 1'b0;
        load       = 1'b0;
        load_rs    = 1'b0;
        load_data  = 8'h00;

        case (state)
            PWR_WAIT: begin
                if (cnt == CW'(TP - 1)) begin
                    load      = 1'b1;
                    load_data = init_byte(2'd0);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    load      = 1'b1;
                    load_rs   = req_rs_i;
                    load_data = req_data_i;
                end
            end
            SETUP: begin
                if (cnt == CW'(1)) begin
                    state_n = PULSE;
                    cnt_n   = CW'(TE);
                    en_n    = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PULSE: begin
                en_n = 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = HOLD;
                    cnt_n   = CW'(TH);
                    en_n    = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == CW'(1)) begin
                    state_n = EXEC;
                    cnt_n   = is_long(rs_q, data_q) ? CW'(TL) : CW'(TC);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            EXEC: begin
                if (cnt == CW'(1)) begin
                    if (done_q) begin
                        state_n = IDLE;
                    end else if (init_idx == 2'd3) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        init_idx_n = init_idx + 2'd1;
                        load       = 1'b1;
                        load_data  = init_byte(init_idx + 2'd1);
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = PWR_WAIT;
                cnt_n   = '0;
            end
        endcase

        if (load) begin
            state_n = SETUP;
            cnt_n   = CW'(TS + 1);
            rs_n    = load_rs;
            data_n  = load_data;
        end

        ready_n = done_n && (state_n == IDLE);
    end

    // State and output registers; reset drops every output immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= PWR_WAIT;
            cnt      <= '0;
            init_idx <= 2'd0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            on_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            init_idx <= init_idx_n;
            done_q   <= done_n;
            ready_q  <= ready_n;
            en_q     <= en_n;
            rs_q     <= rs_n;
            data_q   <= data_n;
            on_q     <= 1'b1;
        end
    end

    assign req_ready_o = ready_q;
    assign init_done_o = done_q;
    assign lcd_en_o    = en_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_rs_o    = rs_q;
    assign lcd_on_o    = on_q;
    assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl with timing reference model
module tb_lcd_ctrl;

    localparam int TS = 1;
    localparam int TE = 2;
    localparam int TH = 1;
    localparam int TC = 4;
    localparam int TL = 8;
    localparam int TP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_en, lcd_rw, lcd_rs, lcd_on;
    logic [7:0] lcd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rw_bad = 0;

    int         rise_q[$];
    int         fall_q[$];
    logic [8:0] fall_val_q[$];
    int         rdy_rise_q[$];
    int         done_q[$];
    int         on_q[$];
    logic       prev_en = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0, prev_on = 1'b0;

    lcd_ctrl #(
        .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLR(TL), .T_PWR(TP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_rs_i(req_rs),
        .req_data_i(req_data), .req_ready_o(req_ready), .init_done_o(init_done),
        .lcd_en_o(lcd_en), .lcd_rw_o(lcd_rw), .lcd_rs_o(lcd_rs), .lcd_on_o(lcd_on),
        .lcd_data_o(lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: edge numbers of EN/ready/done/on transitions, bus value at EN fall
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
        if (lcd_en === 1'b1 && prev_en !== 1'b1) rise_q.push_back(cyc);
        if (lcd_en === 1'b0 && prev_en === 1'b1) begin
            fall_q.push_back(cyc);
            fall_val_q.push_back({lcd_rs, lcd_data});
        end
        if (req_ready === 1'b1 && prev_rdy !== 1'b1) rdy_rise_q.push_back(cyc);
        if (init_done === 1'b1 && prev_done !== 1'b1) done_q.push_back(cyc);
        if (lcd_on === 1'b1 && prev_on !== 1'b1) on_q.push_back(cyc);
        prev_en   <= lcd_en;
        prev_rdy  <= req_ready;
        prev_done <= init_done;
        prev_on   <= lcd_on;
    end

    // Reference model: execution wait and full per-byte period from the byte value
    function automatic int exec_cycles(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TL;
        return TC;
    endfunction

    function automatic int period(input logic rs, input logic [7:0] d);
        return 1 + TS + TE + TH + exec_cycles(rs, d);
    endfunction

    task automatic clear_events();
        rise_q.delete();
        fall_q.delete();
        fall_val_q.delete();
        rdy_rise_q.delete();
        done_q.delete();
        on_q.delete();
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input bit keep,
                            input int budget, output int acc, output bit ok);
        req_rs    = rs;
        req_data  = d;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep || !ok) req_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int edge_n, output bit ok);
        ok     = 1'b0;
        edge_n = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok     = 1'b1;
                edge_n = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'($urandom);
            req_rs    = 1'($urandom);
            req_data  = 8'($urandom);
            @(negedge clk);
        end
        n_cmp++; if (lcd_en !== 1'b0)      begin n_bad++; $display("FAIL reset_en: got %b want 0", lcd_en); end
        n_cmp++; if (lcd_rs !== 1'b0)      begin n_bad++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
        n_cmp++; if (lcd_data !== 8'h00)   begin n_bad++; $display("FAIL reset_data: got %h want 00", lcd_data); end
        n_cmp++; if (lcd_on !== 1'b0)      begin n_bad++; $display("FAIL reset_on: got %b want 0", lcd_on); end
        n_cmp++; if (lcd_rw !== 1'b0)      begin n_bad++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
        n_cmp++; if (req_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if (init_done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", init_done); end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup(input string tag);
        int         rel, acc, rr, t;
        bit         ok;
        logic [7:0] ib[4];
        logic [8:0] ev[5];
        int         er[5];
        int         ef[5];
        ib[0] = 8'h38; ib[1] = 8'h0C; ib[2] = 8'h01; ib[3] = 8'h06;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL %s_done_in_reset: got %b want 0", tag, init_done); end
        clear_events();
        rel   = cyc;
        rst_n = 1'b1;
        do_write(1'b1, 8'h41, 1'b0, 400, acc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_accept_timeout: got none want accept", tag); end
        wait_ready(200, rr, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_ready_timeout: got none want ready", tag); end

        t = rel + TP;
        for (int i = 0; i < 4; i++) begin
            er[i] = t + 1 + TS;
            ef[i] = er[i] + TE;
            ev[i] = {1'b0, ib[i]};
            t     = ef[i] + TH + exec_cycles(1'b0, ib[i]);
        end
        er[4] = t + 2 + TS;
        ef[4] = er[4] + TE;
        ev[4] = {1'b1, 8'h41};

        n_cmp++; if (on_q.size() != 1 || on_q[0] != rel + 1) begin
            n_bad++; $display("FAIL %s_on_rise: got %0d events first %0d want edge %0d", tag, on_q.size(), (on_q.size() > 0) ? on_q[0] : -1, rel + 1);
        end
        n_cmp++; if (done_q.size() != 1 || done_q[0] != t) begin
            n_bad++; $display("FAIL %s_done_rise: got %0d events first %0d want edge %0d", tag, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t);
        end
        n_cmp++; if (rdy_rise_q.size() < 1 || rdy_rise_q[0] != t) begin
            n_bad++; $display("FAIL %s_first_ready: got %0d want edge %0d", tag, (rdy_rise_q.size() > 0) ? rdy_rise_q[0] : -1, t);
        end
        n_cmp++; if (acc != t + 1) begin n_bad++; $display("FAIL %s_accept_edge: got %0d want %0d", tag, acc, t + 1); end
        n_cmp++; if (rr != acc + period(1'b1, 8'h41)) begin
            n_bad++; $display("FAIL %s_ready_return: got %0d want %0d", tag, rr, acc + period(1'b1, 8'h41));
        end
        n_cmp++; if (rise_q.size() != 5 || fall_q.size() != 5) begin
            n_bad++; $display("FAIL %s_pulse_count: got %0d/%0d want 5", tag, rise_q.size(), fall_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (rise_q[i] != er[i]) begin n_bad++; $display("FAIL %s_rise%0d: got %0d want %0d", tag, i, rise_q[i], er[i]); end
                n_cmp++; if (fall_q[i] != ef[i]) begin n_bad++; $display("FAIL %s_fall%0d: got %0d want %0d", tag, i, fall_q[i], ef[i]); end
                n_cmp++; if (fall_val_q[i] !== ev[i]) begin n_bad++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, fall_val_q[i], ev[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, rr;
        bit ok1, ok2, ok3;
        clear_events();
        do_write(1'b1, 8'h48, 1'b1, 50, a1, ok1);
        do_write(1'b1, 8'h49, 1'b0, 50, a2, ok2);
        wait_ready(50, rr, ok3);
        n_cmp++; if (!(ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL b2b_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
        n_cmp++; if (rdy_rise_q.size() < 1 || rdy_rise_q[0] - a1 != 9) begin
            n_bad++; $display("FAIL b2b_ready_low: got %0d want 9", (rdy_rise_q.size() > 0) ? rdy_rise_q[0] - a1 : -1);
        end
        n_cmp++; if (a2 - a1 != 10) begin n_bad++; $display("FAIL b2b_accept_spacing: got %0d want 10", a2 - a1); end
        n_cmp++; if (fall_val_q.size() != 2 || fall_val_q[0] !== 9'h148 || fall_val_q[1] !== 9'h149) begin
            n_bad++; $display("FAIL b2b_bytes: got %0d bytes first %h want 148,149", fall_val_q.size(), (fall_val_q.size() > 0) ? fall_val_q[0] : 9'h0);
        end
    endtask

    task automatic test_commands();
        logic [8:0] cmd[6];
        int         low[6];
        int         acc, rr;
        bit         ok1, ok2;
        cmd[0] = 9'h001; low[0] = 13;
        cmd[1] = 9'h010; low[1] = 9;
        cmd[2] = 9'h000; low[2] = 9;
        cmd[3] = 9'h002; low[3] = 13;
        cmd[4] = 9'h003; low[4] = 13;
        cmd[5] = 9'h101; low[5] = 9;
        for (int i = 0; i < 6; i++) begin
            clear_events();
            do_write(cmd[i][8], cmd[i][7:0], 1'b0, 50, acc, ok1);
            wait_ready(50, rr, ok2);
            n_cmp++; if (!(ok1 && ok2) || rr - acc != low[i]) begin
                n_bad++; $display("FAIL cmd_%h_ready_low: got %0d want %0d", cmd[i], rr - acc, low[i]);
            end
            n_cmp++; if (fall_val_q.size() != 1 || fall_val_q[0] !== cmd[i]) begin
                n_bad++; $display("FAIL cmd_%h_bus: got %h want %h", cmd[i], (fall_val_q.size() > 0) ? fall_val_q[0] : 9'h0, cmd[i]);
            end
        end
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] d;
        int         acc, rr;
        bit         ok1, ok2;
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 3));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            clear_events();
            do_write(rs, d, 1'b0, 50, acc, ok1);
            wait_ready(50, rr, ok2);
            n_cmp++; if (!(ok1 && ok2) || rr - acc != period(rs, d) - 1 + 1) begin
                n_bad++; $display("FAIL rand%0d_ready_low: got %0d want %0d", i, rr - acc, period(rs, d));
            end
            n_cmp++; if (rise_q.size() != 1 || fall_q.size() != 1 || rise_q[0] != acc + 1 + TS || fall_q[0] - rise_q[0] != TE) begin
                n_bad++; $display("FAIL rand%0d_en_timing: got rise %0d fall %0d want rise %0d width %0d", i,
                                  (rise_q.size() > 0) ? rise_q[0] : -1, (fall_q.size() > 0) ? fall_q[0] : -1, acc + 1 + TS, TE);
            end
            n_cmp++; if (fall_val_q.size() != 1 || fall_val_q[0] !== {rs, d}) begin
                n_bad++; $display("FAIL rand%0d_bus: got %h want %h", i, (fall_val_q.size() > 0) ? fall_val_q[0] : 9'h0, {rs, d});
            end
        end
    endtask

    task automatic test_reset_in_pulse();
        int acc;
        bit ok, seen;
        clear_events();
        do_write(1'b1, 8'($urandom), 1'b0, 50, acc, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rip_en_timeout: got 0 want 1"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (lcd_en !== 1'b0)    begin n_bad++; $display("FAIL rip_en_async: got %b want 0", lcd_en); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rip_ready_async: got %b want 0", req_ready); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rip_done_async: got %b want 0", init_done); end
        test_powerup("rerun");
    endtask

    task automatic test_rw();
        n_cmp++; if (rw_bad !== 0) begin n_bad++; $display("FAIL rw_always_zero: got %0d nonzero cycles want 0", rw_bad); end
    endtask

    initial begin
        test_reset();
        test_powerup("init");
        test_back_to_back();
        test_commands();
        test_random();
        test_reset_in_pulse();
        test_back_to_back();
        test_rw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
